me_sequencer: RTL and testbench
===============================

// Module: me_sequencer
// PURPOSE
//   Control unit in front of the motion estimator (ME) core: accepts a pixel stream,
//   writes 256 reference pixels then 961 search pixels into the ME memories, runs the
//   ME, captures motionX/motionY/bestDistance and offers them on a valid/ready port.
//   Sits between the frame fetch logic and the ME datapath; one block search per run.
// PARAMETERS
//   RMEM_MAX        256    reference memory depth (16x16 block)
//   SMEM_MAX        961    search memory depth (31x31 window)
//   TIMEOUT_CYCLES  4096   watchdog limit in WAIT (used only with ME_TIMEOUT_EN)
// PORTS
//   clk              in   1   single clock, all logic on posedge
//   reset            in   1   asynchronous, active-high; one clock, no other domain
//   in_valid         in   1   pixel stream valid
//   in_ready         out  1   pixel accepted when in_valid && in_ready
//   in_data          in   8   pixel: reference raster first, then search raster
//   ref_we           out  1   reference memory write enable
//   ref_waddr        out  8   reference write address
//   search_we        out  1   search memory write enable
//   search_waddr     out  10  search write address
//   mem_wdata        out  8   write data shared by both memories
//   me_start         out  1   ME start, level
//   me_completed     in   1   ME done, level
//   me_motion_x      in   4   ME result X
//   me_motion_y      in   4   ME result Y
//   me_best_distance in   8   ME best SAD
//   res_valid        out  1   result valid
//   res_ready        in   1   result consumed when res_valid && res_ready
//   res_motion_x     out  4   captured X
//   res_motion_y     out  4   captured Y
//   res_distance     out  8   captured bestDistance
//   res_error        out  1   result is a timeout, not a real search
//   busy             out  1   state != IDLE
// BEHAVIOUR
//   Reset: state IDLE; counters 0; all outputs 0.
//   FSM: IDLE -> LOAD_R on first in_valid. LOAD_R: in_ready=1; each accepted beat
//     drives ref_we=1, ref_waddr=cnt, mem_wdata=in_data in the same cycle
//     (combinational, 0 latency); cnt++; beat RMEM_MAX-1 -> LOAD_S with cnt=0.
//     LOAD_S: same with search_we/search_waddr; beat SMEM_MAX-1 -> RUN.
//     RUN: me_start=1 (registered); ignore me_completed in first RUN cycle (stale
//     level); next sample of me_completed=1 captures the result fields, drops
//     me_start, sets res_valid -> RESULT.
//     RESULT: res_* stable while !res_ready; on handshake res_valid=0 -> IDLE.
//   in_ready=0 outside LOAD_R/LOAD_S; in_valid gaps stall the counter with no write.
//   Write enables never assert without an accepted beat; never both in one cycle.
//   Counters saturate at depth-1 then reset to 0 on transition; no wrap beyond.
//   Reset mid-run: immediate return to IDLE, me_start=0, res_valid=0, partial
//     memory contents abandoned (next run rewrites all addresses).
//   Total load = 1217 accepted beats; min run start-to-res_valid = 1 + ME latency.
// CONFIGURATION
//   ME_TIMEOUT_EN defined: 13-bit counter in RUN; reaching TIMEOUT_CYCLES without
//     me_completed -> me_start=0, res_error=1, res_motion_x/y=0, res_distance=8'hFF,
//     res_valid=1 -> RESULT. Completed in the same cycle as timeout wins (no error).
//   Not defined: no counter; RUN waits forever; res_error tied 0.
// STRUCTURE
//   Package me_pkg: RMEM_MAX/SMEM_MAX constants, address widths, typedef enum
//     me_seq_state_t {IDLE, LOAD_R, LOAD_S, RUN, RESULT}, typedef struct
//     me_result_t {motion_x, motion_y, distance, error}.
//   Sub-module me_watchdog (counter + expire flag), instantiated only under
//     ME_TIMEOUT_EN. FSM and load counter stay in me_sequencer.
// TESTING
//   1217 back-to-back beats, data = addr[7:0] -> ref writes 0..255, search writes
//     0..960, me_start rises the cycle after beat 1217.
//   Random in_valid gaps (50%) -> identical memory image, no write on idle cycles.
//   ME model completes after 20 cycles with X=4'd3,Y=4'd12,dist=8'd37 -> res_valid
//     with those values; res_ready held low 10 cycles -> fields stable, then IDLE.
//   Assert reset during LOAD_S at beat 600 -> outputs 0 next edge; full reload
//     afterward runs clean.
//   me_completed held high from previous run into RUN first cycle -> not captured.
//   ME_TIMEOUT_EN, TIMEOUT_CYCLES=64, ME never completes -> res_error=1,
//     res_distance=8'hFF after 64 RUN cycles; completion on cycle 64 -> no error.

Source files
------------

// File: rtl/me_pkg.sv
// Shared constants and types for the motion-estimator sequencer.
// Build option: ME_TIMEOUT_EN enables the RUN-state watchdog.
package me_pkg;

  localparam int RMEM_MAX = 256;
  localparam int SMEM_MAX = 961;
  localparam int RADDR_W  = 8;
  localparam int SADDR_W  = 10;
  localparam int CNT_W    = 10;
  localparam int WDOG_W   = 13;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_R = 3'd1,
    LOAD_S = 3'd2,
    RUN    = 3'd3,
    RESULT = 3'd4
  } me_seq_state_t;

  typedef struct packed {
    logic [3:0] motion_x;
    logic [3:0] motion_y;
    logic [7:0] distance;
    logic       error;
  } me_result_t;

endpackage

// File: rtl/me_watchdog.sv
// RUN-state cycle counter with an expire flag on the last allowed cycle.
// Only instantiated when ME_TIMEOUT_EN is defined.
module me_watchdog
  import me_pkg::*;
#(
  parameter int LIMIT = 4096
) (
  input  logic clk,
  input  logic reset,
  input  logic run_i,
  output logic expire_o
);

  logic [WDOG_W-1:0] cnt_q;
  logic [WDOG_W-1:0] cnt_d;
  logic              last;

  assign last     = (cnt_q == WDOG_W'(LIMIT - 1));
  assign expire_o = run_i && last;

  // Count RUN cycles; clear whenever RUN is left, hold at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (!run_i)
      cnt_d = '0;
    else if (!last)
      cnt_d = cnt_q + 1'b1;
  end

  // Counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/me_sequencer.sv
// Loads reference/search memories from a pixel stream, runs the ME core
// and holds its result on a valid/ready port. Option: ME_TIMEOUT_EN.
module me_sequencer
  import me_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [7:0]         in_data,
  output logic               ref_we,
  output logic [RADDR_W-1:0] ref_waddr,
  output logic               search_we,
  output logic [SADDR_W-1:0] search_waddr,
  output logic [7:0]         mem_wdata,
  output logic               me_start,
  input  logic               me_completed,
  input  logic [3:0]         me_motion_x,
  input  logic [3:0]         me_motion_y,
  input  logic [7:0]         me_best_distance,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [3:0]         res_motion_x,
  output logic [3:0]         res_motion_y,
  output logic [7:0]         res_distance,
  output logic               res_error,
  output logic               busy
);

  me_seq_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             first_q, first_d;
  logic             start_q, start_d;
  logic             valid_q, valid_d;
  me_result_t       res_q, res_d;
  logic             accept;
  logic             wd_expire;

`ifdef ME_TIMEOUT_EN
  me_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_wdog (
    .clk      (clk),
    .reset    (reset),
    .run_i    (state_q == RUN),
    .expire_o (wd_expire)
  );
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYCLES;
  assign wd_expire  = 1'b0;
`endif

  assign in_ready     = (state_q == LOAD_R) || (state_q == LOAD_S);
  assign accept       = in_valid && in_ready;
  assign ref_we       = accept && (state_q == LOAD_R);
  assign search_we    = accept && (state_q == LOAD_S);
  assign ref_waddr    = ref_we ? cnt_q[RADDR_W-1:0] : '0;
  assign search_waddr = search_we ? cnt_q : '0;
  assign mem_wdata    = accept ? in_data : 8'd0;

  assign me_start     = start_q;
  assign res_valid    = valid_q;
  assign res_motion_x = res_q.motion_x;
  assign res_motion_y = res_q.motion_y;
  assign res_distance = res_q.distance;
  assign res_error    = res_q.error;
  assign busy         = (state_q != IDLE);

  // Next-state logic: load counters, ME handshake and result capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    start_d = start_q;
    valid_d = valid_q;
    res_d   = res_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (in_valid)
          state_d = LOAD_R;
      end
      LOAD_R: begin
        if (accept) begin
          if (cnt_q == CNT_W'(RMEM_MAX - 1)) begin
            cnt_d   = '0;
            state_d = LOAD_S;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      LOAD_S: begin
        if (accept) begin
          if (cnt_q == CNT_W'(SMEM_MAX - 1)) begin
            cnt_d   = '0;
            state_d = RUN;
            start_d = 1'b1;
            first_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      RUN: begin
        first_d = 1'b0;
        // Done level left over from a previous run is ignored for one cycle.
        if (!first_q && me_completed) begin
          res_d.motion_x = me_motion_x;
          res_d.motion_y = me_motion_y;
          res_d.distance = me_best_distance;
          res_d.error    = 1'b0;
          start_d        = 1'b0;
          valid_d        = 1'b1;
          state_d        = RESULT;
        end else if (wd_expire) begin
          res_d.motion_x = 4'd0;
          res_d.motion_y = 4'd0;
          res_d.distance = 8'hFF;
          res_d.error    = 1'b1;
          start_d        = 1'b0;
          valid_d        = 1'b1;
          state_d        = RESULT;
        end
      end
      RESULT: begin
        if (res_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        start_d = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  // State registers; reset abandons any load or run in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      first_q <= 1'b0;
      start_q <= 1'b0;
      valid_q <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
      start_q <= start_d;
      valid_q <= valid_d;
      res_q   <= res_d;
    end
  end

endmodule

// File: tb/tb_me_sequencer.sv
// Directed bench for me_sequencer: write scoreboard plus result queue.
// Build option: ME_TIMEOUT_EN adds the watchdog scenarios (limit 64).
module tb_me_sequencer;
  import me_pkg::*;

  localparam int TMO   = 64;
  localparam int TOTAL = RMEM_MAX + SMEM_MAX;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        ref_we;
  logic [7:0]  ref_waddr;
  logic        search_we;
  logic [9:0]  search_waddr;
  logic [7:0]  mem_wdata;
  logic        me_start;
  logic        me_completed;
  logic [3:0]  me_motion_x;
  logic [3:0]  me_motion_y;
  logic [7:0]  me_best_distance;
  logic        res_valid;
  logic        res_ready;
  logic [3:0]  res_motion_x;
  logic [3:0]  res_motion_y;
  logic [7:0]  res_distance;
  logic        res_error;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit         s;
    int         addr;
    logic [7:0] data;
  } wr_t;

  wr_t        wq[$];
  me_result_t rq[$];

  always #5 clk = ~clk;

  me_sequencer #(
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_data          (in_data),
    .ref_we           (ref_we),
    .ref_waddr        (ref_waddr),
    .search_we        (search_we),
    .search_waddr     (search_waddr),
    .mem_wdata        (mem_wdata),
    .me_start         (me_start),
    .me_completed     (me_completed),
    .me_motion_x      (me_motion_x),
    .me_motion_y      (me_motion_y),
    .me_best_distance (me_best_distance),
    .res_valid        (res_valid),
    .res_ready        (res_ready),
    .res_motion_x     (res_motion_x),
    .res_motion_y     (res_motion_y),
    .res_distance     (res_distance),
    .res_error        (res_error),
    .busy             (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory write monitor: every write pops one expected beat.
  always @(negedge clk) begin
    wr_t e;
    if (ref_we || search_we) begin
      chk("we_exclusive", 32'(ref_we & search_we), 0);
      chk("we_needs_valid", 32'(in_valid), 1);
      if (wq.size() == 0) begin
        chk("unexpected_write", {ref_we, search_we}, 0);
      end else begin
        e = wq.pop_front();
        chk("we_kind", 32'(search_we), 32'(e.s));
        chk("waddr", e.s ? 32'(search_waddr) : 32'(ref_waddr), e.addr);
        chk("wdata", mem_wdata, e.data);
      end
    end
  end

  task automatic load(input int n, input bit gaps);
    int w;
    bit ok;
    wr_t e;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        while ($urandom_range(1, 0) == 1) begin
          in_valid = 1'b0;
          @(posedge clk); #1;
        end
      end
      e.s    = (i >= RMEM_MAX);
      e.addr = e.s ? i - RMEM_MAX : i;
      e.data = 8'(e.addr);
      in_valid = 1'b1;
      in_data  = e.data;
      wq.push_back(e);
      w  = 0;
      ok = 1'b0;
      do begin
        @(negedge clk);
        ok = in_ready;
        if (ok && i == TOTAL - 1)
          chk("start_not_early", 32'(me_start), 0);
        @(posedge clk); #1;
        w++;
      end while (!ok && w < 64);
      if (!ok) begin
        chk("load_stall", 32'(in_ready), 1);
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    if (n == TOTAL) begin
      chk("wq_drained", wq.size(), 0);
      chk("in_ready_run", 32'(in_ready), 0);
    end
  endtask

  task automatic run_me(input int lat, input logic [3:0] x, input logic [3:0] y,
                        input logic [7:0] d, input bit never, input bit stale);
    int         cyc;
    int         exp_lat;
    me_result_t e;
    me_result_t g;
    cyc = 0;
    chk("start_rise", 32'(me_start), 1);
    chk("busy_run", 32'(busy), 1);
    if (stale) begin
      @(posedge clk); #1;
      cyc++;
      me_completed = 1'b0;
      chk("stale_ignored", 32'(res_valid), 0);
    end
    if (never) begin
      e.motion_x = 4'd0;
      e.motion_y = 4'd0;
      e.distance = 8'hFF;
      e.error    = 1'b1;
      exp_lat    = TMO;
    end else begin
      while (cyc < lat) begin
        @(posedge clk); #1;
        cyc++;
      end
      me_motion_x      = x;
      me_motion_y      = y;
      me_best_distance = d;
      me_completed     = 1'b1;
      e.motion_x = x;
      e.motion_y = y;
      e.distance = d;
      e.error    = 1'b0;
      exp_lat    = lat + 1;
    end
    rq.push_back(e);
    while (!res_valid && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
    end
    me_completed = 1'b0;
    chk("run_latency", cyc, exp_lat);
    chk("start_drop", 32'(me_start), 0);
    g = rq.pop_front();
    for (int k = 0; k < 10; k++) begin
      chk("res_valid_hold", 32'(res_valid), 1);
      chk("res_x", res_motion_x, g.motion_x);
      chk("res_y", res_motion_y, g.motion_y);
      chk("res_dist", res_distance, g.distance);
      chk("res_err", 32'(res_error), 32'(g.error));
      @(posedge clk); #1;
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk("res_valid_clear", 32'(res_valid), 0);
    chk("busy_idle", 32'(busy), 0);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_in_ready"}, 32'(in_ready), 0);
    chk({tag, "_we"}, {ref_we, search_we}, 0);
    chk({tag, "_start"}, 32'(me_start), 0);
    chk({tag, "_res_valid"}, 32'(res_valid), 0);
    chk({tag, "_wdata"}, mem_wdata, 0);
  endtask

  initial begin
    reset            = 1'b1;
    in_valid         = 1'b0;
    in_data          = 8'd0;
    me_completed     = 1'b0;
    me_motion_x      = 4'd0;
    me_motion_y      = 4'd0;
    me_best_distance = 8'd0;
    res_ready        = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_quiet("reset");
    chk("reset_res_x", res_motion_x, 0);
    chk("reset_res_dist", res_distance, 0);
    chk("reset_res_err", 32'(res_error), 0);
    reset = 1'b0;
    @(posedge clk); #1;

    load(TOTAL, 1'b0);
    run_me(20, 4'd3, 4'd12, 8'd37, 1'b0, 1'b0);

    load(TOTAL, 1'b1);
    run_me(20, 4'd5, 4'd9, 8'd200, 1'b0, 1'b0);

    load(RMEM_MAX + 600, 1'b0);
    in_valid = 1'b1;
    reset    = 1'b1;
    #1;
    chk_quiet("midrst");
    @(posedge clk); #1;
    chk_quiet("midrst_edge");
    chk("midrst_wq", wq.size(), 0);
    in_valid = 1'b0;
    reset    = 1'b0;
    @(posedge clk); #1;
    load(TOTAL, 1'b1);
    run_me(20, 4'd3, 4'd12, 8'd37, 1'b0, 1'b0);

    me_motion_x      = 4'd1;
    me_motion_y      = 4'd1;
    me_best_distance = 8'd99;
    me_completed     = 1'b1;
    load(TOTAL, 1'b0);
    run_me(20, 4'd3, 4'd12, 8'd37, 1'b0, 1'b1);

`ifdef ME_TIMEOUT_EN
    load(TOTAL, 1'b0);
    run_me(0, 4'd0, 4'd0, 8'd0, 1'b1, 1'b0);
    load(TOTAL, 1'b0);
    run_me(TMO - 1, 4'd7, 4'd2, 8'd50, 1'b0, 1'b0);
`else
    load(TOTAL, 1'b0);
    run_me(100, 4'd15, 4'd0, 8'd255, 1'b0, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
